// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between a datapath and its data memory.
interface dmem_responder_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Extracts and extends the addressed byte/halfword/word and flags illegal or
// misaligned accesses; the flag also gates store commits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_B:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  begin
        err  = addr_lo[0];
        data = {{16{half_sel[15]}}, half_sel};
      end
      F3_W:  begin
        err  = |addr_lo;
        data = word;
      end
      // unsigned variants exist only for loads
      F3_BU: begin
        err  = is_store;
        data = {24'b0, byte_sel};
      end
      F3_HU: begin
        err  = is_store | addr_lo[0];
        data = {16'b0, half_sel};
      end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, answered after WAIT_CYCLES wait states.
// state | meaning
// IDLE  | ready for a request (ready held low for one cycle after reset)
// WAIT  | request latched, wait counter running down
// RESP  | store committed on entry; response registered for the next cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  dmem_responder_if.slave   bus
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]     mem_q [WORDS];

  logic                  accept;
  logic                  cur_wr;
  logic [2:0]            cur_f3;
  logic [DM_ADDRESS-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic [DATA_W-1:0]     rd_word;
  logic [DATA_W-1:0]     ld_data;
  logic                  align_err;
  logic [3:0]            byte_en;
  logic [DATA_W-1:0]     st_lanes;
  logic                  commit;

  assign accept = (state_q == IDLE) && bus.req_valid && req_ready_q;

  // With zero wait states the store commits on the accept edge itself, so the
  // live request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == IDLE) begin
      cur_wr    = bus.req_write;
      cur_f3    = bus.req_funct3;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_wr    = wr_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign rd_word = mem_q[cur_addr[DM_ADDRESS-1:2]];

  dmem_load_align u_align (
    .word     (rd_word),
    .addr_lo  (cur_addr[1:0]),
    .funct3   (cur_f3),
    .is_store (cur_wr),
    .data     (ld_data),
    .err      (align_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = bus.req_write;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - WAIT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_q == RESP);
    rsp_err_d   = (state_q == RESP) && align_err;
    rsp_rdata_d = ((state_q == RESP) && !cur_wr) ? ld_data : '0;
  end

  always_comb begin
    byte_en  = 4'b1111;
    st_lanes = cur_wdata;
    case (cur_f3)
      F3_B: begin
        byte_en  = 4'b0001 << cur_addr[1:0];
        st_lanes = {4{cur_wdata[7:0]}};
      end
      F3_H: begin
        byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        st_lanes = cur_wdata;
      end
    endcase
  end

  assign commit = !reset && cur_wr && !align_err &&
                  (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[cur_addr[DM_ADDRESS-1:2]][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-array memory model checks both a 2-wait-state and a
// 0-wait-state instance every cycle, while directed requests pin literal results.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst2;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus0 ();
  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus2 ();

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0));
  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst2), .bus(bus2));

  // index 0 -> zero-wait instance, index 1 -> two-wait instance
  function automatic int wc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  logic [7:0]  mmem  [2][512];
  bit          pv    [2] = '{0, 0};
  int          pdue  [2];
  logic        pw    [2];
  logic [2:0]  pf3   [2];
  logic [8:0]  pa    [2];
  logic [31:0] pwd   [2];
  int          rfrom [2] = '{32'h7fffffff, 32'h7fffffff};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_resp(input int d, output logic [31:0] ed, output logic ee);
    int n;
    bit legal;
    logic [31:0] v;
    n = (pf3[d][1:0] == 2'b00) ? 1 : (pf3[d][1:0] == 2'b01) ? 2 : 4;
    case (pf3[d])
      3'b000:  legal = 1;
      3'b001:  legal = (pa[d][0] == 1'b0);
      3'b010:  legal = (pa[d][1:0] == 2'b00);
      3'b100:  legal = !pw[d];
      3'b101:  legal = !pw[d] && (pa[d][0] == 1'b0);
      default: legal = 0;
    endcase
    ed = 32'h0;
    ee = 1'b0;
    if (!legal) begin
      ee = 1'b1;
    end else if (pw[d]) begin
      for (int i = 0; i < n; i++) mmem[d][int'(pa[d]) + i] = pwd[d][8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mmem[d][int'(pa[d]) + i]) << (8 * i));
      if (!pf3[d][2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      ed = v;
    end
  endtask

  task automatic mon(input int d, input logic rst, input logic v, input logic w,
                     input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
                     input logic rdy, input logic rv, input logic [31:0] rd, input logic er);
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    bit          mready;
    if (cyc >= 1) begin
      ev = pv[d] && (pdue[d] == cyc);
      ed = 32'h0;
      ee = 1'b0;
      if (ev) begin
        model_resp(d, ed, ee);
        pv[d] = 0;
      end
      chk($sformatf("dut%0d req_ready", d), 32'(rdy), 32'(cyc >= rfrom[d]));
      chk($sformatf("dut%0d rsp_valid", d), 32'(rv), 32'(ev));
      chk($sformatf("dut%0d rsp_rdata", d), rd, ed);
      chk($sformatf("dut%0d rsp_err", d), 32'(er), 32'(ee));
    end
    mready = (cyc >= rfrom[d]);
    if (rst) begin
      pv[d]    = 0;
      rfrom[d] = cyc + 2;
    end else if (v && mready) begin
      pv[d]    = 1;
      pdue[d]  = cyc + 2 + wc(d);
      rfrom[d] = cyc + 2 + wc(d);
      pw[d]    = w;
      pf3[d]   = f3;
      pa[d]    = a;
      pwd[d]   = wd;
    end
  endtask

  always @(negedge clk)
    mon(0, rst0, bus0.req_valid, bus0.req_write, bus0.req_funct3, bus0.req_addr,
        bus0.req_wdata, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
  always @(negedge clk)
    mon(1, rst2, bus2.req_valid, bus2.req_write, bus2.req_funct3, bus2.req_addr,
        bus2.req_wdata, bus2.req_ready, bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err);

  task automatic set_req(input int d, input logic v, input logic w, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.req_valid = v; bus0.req_write = w; bus0.req_funct3 = f3;
      bus0.req_addr = a;  bus0.req_wdata = wd;
    end else begin
      bus2.req_valid = v; bus2.req_write = w; bus2.req_funct3 = f3;
      bus2.req_addr = a;  bus2.req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus0.req_ready : bus2.req_ready;
  endfunction
  function automatic logic get_rv(input int d);
    return (d == 0) ? bus0.rsp_valid : bus2.rsp_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? bus0.rsp_rdata : bus2.rsp_rdata;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? bus0.rsp_err : bus2.rsp_err;
  endfunction

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
  endtask

  task automatic req(input int d, input logic w, input logic [2:0] f3, input logic [8:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input string name);
    int t_acc, n;
    bit ok;
    set_req(d, 1'b1, w, f3, a, wd);
    ok = 0; n = 0; t_acc = 0;
    while (!ok && n < 20) begin
      @(negedge clk); n++;
      if (get_ready(d)) begin ok = 1; t_acc = cyc + 1; end
    end
    @(posedge clk); #1;
    set_req(d, 1'b0, 1'b0, 3'b0, 9'h0, 32'h0);
    if (!ok) begin
      timeout_fail({name, " accept"});
      return;
    end
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); n++;
      if (get_rv(d)) ok = 1;
    end
    if (!ok) begin
      timeout_fail({name, " response"});
    end else begin
      chk({name, " latency"}, 32'(cyc - t_acc), 32'(1 + wc(d)));
      chk({name, " rdata"}, get_rd(d), exp_d);
      chk({name, " err"}, 32'(get_err(d)), 32'(exp_e));
      @(negedge clk);
      chk({name, " one-cycle strobe"}, 32'(get_rv(d)), 32'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input int d, input logic [2:0] f3, input logic [8:0] base, input int count);
    int tprev, t, n;
    bit ok;
    tprev = 0;
    for (int k = 0; k < count; k++) begin
      set_req(d, 1'b1, 1'b0, f3, 9'(base + k), 32'h0);
      ok = 0; n = 0; t = 0;
      while (!ok && n < 20) begin
        @(negedge clk); n++;
        if (get_ready(d)) begin ok = 1; t = cyc + 1; end
      end
      if (!ok) begin
        timeout_fail($sformatf("dut%0d stream accept %0d", d, k));
        break;
      end
      @(posedge clk);
      if (k > 0) chk($sformatf("dut%0d accept interval", d), 32'(t - tprev), 32'(wc(d) + 2));
      tprev = t;
      #1;
    end
    set_req(d, 1'b0, 1'b0, 3'b0, 9'h0, 32'h0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n, seen;
    bit  ok;
    rst0 = 1'b1;
    rst2 = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'b0, 9'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 3'b0, 9'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset req_ready", 32'(get_ready(d)), 32'h0);
      chk("reset rsp_valid", 32'(get_rv(d)), 32'h0);
      chk("reset rsp_rdata", get_rd(d), 32'h0);
      chk("reset rsp_err", 32'(get_err(d)), 32'h0);
    end
    @(posedge clk); #1;
    rst0 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("ready low first cycle after reset", 32'(get_ready(1)), 32'h0);
    @(negedge clk);
    chk("ready high in idle", 32'(get_ready(1)), 32'h1);
    @(posedge clk); #1;

    req(1, 1'b1, F3_W,  9'h010, 32'hDEADBEEF, 32'h0,        1'b0, "SW 010");
    req(1, 1'b0, F3_W,  9'h010, 32'h0,        32'hDEADBEEF, 1'b0, "LW 010");
    req(1, 1'b0, F3_B,  9'h013, 32'h0,        32'hFFFFFFDE, 1'b0, "LB 013");
    req(1, 1'b0, F3_BU, 9'h013, 32'h0,        32'h000000DE, 1'b0, "LBU 013");
    req(1, 1'b0, F3_H,  9'h012, 32'h0,        32'hFFFFDEAD, 1'b0, "LH 012");
    req(1, 1'b0, F3_HU, 9'h010, 32'h0,        32'h0000BEEF, 1'b0, "LHU 010");
    req(1, 1'b1, F3_B,  9'h011, 32'h000000AA, 32'h0,        1'b0, "SB 011");
    req(1, 1'b0, F3_W,  9'h010, 32'h0,        32'hDEADAAEF, 1'b0, "LW after SB");
    req(1, 1'b1, F3_H,  9'h012, 32'h00001234, 32'h0,        1'b0, "SH 012");
    req(1, 1'b0, F3_W,  9'h010, 32'h0,        32'h1234AAEF, 1'b0, "LW after SH");
    req(1, 1'b0, F3_W,  9'h012, 32'h0,        32'h0,        1'b1, "LW misaligned");
    req(1, 1'b1, F3_H,  9'h013, 32'h00005555, 32'h0,        1'b1, "SH misaligned");
    req(1, 1'b0, 3'b011, 9'h010, 32'h0,       32'h0,        1'b1, "load funct3 011");
    req(1, 1'b1, F3_BU, 9'h010, 32'h00000077, 32'h0,        1'b1, "store funct3 100");
    req(1, 1'b0, F3_W,  9'h010, 32'h0,        32'h1234AAEF, 1'b0, "LW after errors");

    stream(1, F3_BU, 9'h010, 4);

    set_req(1, 1'b1, 1'b1, F3_W, 9'h010, 32'h0);
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); n++;
      if (get_ready(1)) ok = 1;
    end
    if (!ok) timeout_fail("reset test accept");
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 3'b0, 9'h0, 32'h0);
    rst2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready during reset", 32'(get_ready(1)), 32'h0);
    chk("rsp_valid during reset", 32'(get_rv(1)), 32'h0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    chk("ready one cycle after reset", 32'(get_ready(1)), 32'h0);
    @(negedge clk);
    chk("ready back after reset", 32'(get_ready(1)), 32'h1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (get_rv(1)) seen++;
    end
    chk("no response for discarded store", 32'(seen), 32'h0);
    @(posedge clk); #1;
    req(1, 1'b0, F3_W, 9'h010, 32'h0, 32'h1234AAEF, 1'b0, "LW after reset");

    req(0, 1'b1, F3_W,  9'h020, 32'h11223344, 32'h0,        1'b0, "w0 SW 020");
    req(0, 1'b0, F3_W,  9'h020, 32'h0,        32'h11223344, 1'b0, "w0 LW 020");
    req(0, 1'b1, F3_H,  9'h022, 32'h0000BEEF, 32'h0,        1'b0, "w0 SH 022");
    req(0, 1'b0, F3_W,  9'h020, 32'h0,        32'hBEEF3344, 1'b0, "w0 LW after SH");
    req(0, 1'b0, F3_H,  9'h021, 32'h0,        32'h0,        1'b1, "w0 LH misaligned");
    stream(0, F3_BU, 9'h020, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the datapath's load/store interface.
- Accepts one load or store request through a valid/ready handshake and services it after a fixed number of wait states. It returns one response per request: read data or a completion, plus an error flag.
- Replaces the zero-latency data memory so that later multi-cycle and pipelined datapaths can be run against realistic memory timing.

Parameters:
- DATA_W, 32, data width in bits. Only 32 is supported.
- DM_ADDRESS, 9, byte-address width. Storage is 2**DM_ADDRESS bytes.
- WAIT_CYCLES, 2, number of wait states between request accept and response. Legal range is 0..15.

Ports:
- clk  in  1  clock; everything is sampled on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/sign, using the RV32I load/store funct3 encoding
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data; the value is right-aligned in the low bits
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  load result; 0 for stores and for errors
- rsp_err  out  1  the request was illegal or misaligned

Behaviour:
- Reset and clock:
  - One clock; reset is synchronous and active-high.
  - While reset is high at a clock edge: the state goes to IDLE; req_ready, rsp_valid, rsp_err and rsp_rdata are set to 0; any pending request is discarded with no memory write and no response.
  - Memory contents are not reset and survive reset.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: req_ready=1, except in the first cycle after reset, where the registered req_ready is still 0. When req_valid && req_ready at an edge, the responder latches write, funct3, addr and wdata, then goes to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
  - WAIT: req_ready=0. A wait counter counts WAIT_CYCLES edges, then the FSM goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- Latency and throughput:
  - A request accepted at edge T gives rsp_valid high in the cycle after edge T+1+WAIT_CYCLES.
  - Maximum throughput is one request every WAIT_CYCLES+2 cycles.
  - While req_ready=0, req_valid is ignored. The requester must hold its request stable.
- Store commit:
  - A store writes memory on the edge that enters RESP, only if it is legal.
  - A load issued after that store's response observes the new data.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets rsp_err=1 and rsp_rdata=0, with no write.
- Alignment:
  - Halfword accesses need addr[0]=0; word accesses need addr[1:0]=00.
  - A misaligned access sets rsp_err=1 and rsp_rdata=0, with no write.
  - Because accesses are aligned, they never cross the top of memory, so no wrap-around is needed.
- Byte order and load extension:
  - Byte order is little-endian: byte addr+0 maps to bits [7:0].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
  - SB and SH write only the addressed bytes; the other bytes are unchanged.
- Response fields:
  - For a legal store: rsp_err=0 and rsp_rdata=0.
  - rsp_rdata and rsp_err are 0 whenever rsp_valid=0.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum: IDLE, WAIT, RESP
  - the wait-counter width constant
- Sub-module dmem_load_align is purely combinational. It takes the word, addr[1:0] and funct3, and produces the extracted, extended data plus a misalign/illegal flag. It is shared by the load path and the store error check.

Test Plan (WAIT_CYCLES=2 unless stated):
- SW 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid is high exactly in the cycle after edge T+3 of each accept, and for one cycle only.
- After that store: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
- SB 0x011 data 0x000000AA, then LW 0x010 -> 0xDEADAAEF. SH 0x012 data 0x00001234, then LW 0x010 -> 0x1234AAEF.
- LW 0x012 -> rsp_err=1, rsp_rdata=0. SH 0x013 -> rsp_err=1. funct3=011 load -> rsp_err=1. A following LW 0x010 still returns 0x1234AAEF.
- req_valid held high continuously with different addresses -> req_ready=0 in WAIT and RESP, and one accept every 4 cycles. Repeat with WAIT_CYCLES=0 -> one accept every 2 cycles, and rsp_valid in the cycle after edge T+1.
- Assert reset during WAIT of SW 0x010 data 0x0 -> no rsp_valid, and req_ready=0 through reset plus one cycle. A subsequent LW 0x010 returns the prior value, unchanged.
